// File: rtl/pc_sequencer.sv
// Next-PC generator: sequential / branch / jump / call / return selection with a
// circular return-address stack, halt/resume control and stall/valid gating.
module pc_sequencer #(
  parameter int PC_W        = 9,
  parameter int STACK_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PC_W-1:0]              pc,
  input  logic                         instr_valid,
  input  logic                         stall,
  input  logic                         jump_req,
  input  logic [PC_W-1:0]              jump_target,
  input  logic                         call_req,
  input  logic [PC_W-1:0]              call_target,
  input  logic                         ret_req,
  input  logic                         branch_taken,
  input  logic [PC_W-1:0]              branch_offset,
  input  logic                         halt,
  input  logic                         resume,
  output logic [PC_W-1:0]              pcNext,
  output logic                         enable,
  output logic                         halted,
  output logic [$clog2(STACK_DEPTH):0] stack_depth,
  output logic                         stack_overflow,
  output logic                         stack_underflow
);

  localparam int SP_W    = $clog2(STACK_DEPTH);
  localparam int DEPTH_W = SP_W + 1;
  localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(STACK_DEPTH);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     stack_q [STACK_DEPTH];
  logic [SP_W-1:0]     sp_q, sp_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                push, pop, accept;
  logic [PC_W-1:0]     pc_inc, top, pc_next_c;

  assign pc_inc = pc + PC_W'(1);
  // sp_q is the next free slot, so the most recent push sits one below it.
  assign top    = stack_q[sp_q - SP_W'(1)];
  assign accept = rst && (state_q == RUN) && instr_valid && !stall;

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    depth_d   = depth_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    push      = 1'b0;
    pop       = 1'b0;
    pc_next_c = pc;

    if (accept) begin
      if (jump_req) begin
        pc_next_c = jump_target;
      end else if (call_req) begin
        pc_next_c = call_target;
        push      = 1'b1;
      end else if (ret_req) begin
        if (depth_q != '0) begin
          pc_next_c = top;
          pop       = 1'b1;
        end else begin
          pc_next_c = pc_inc;
          unf_d     = 1'b1;
        end
      end else if (branch_taken) begin
        pc_next_c = pc + branch_offset;
      end else begin
        pc_next_c = pc_inc;
      end
    end

    // A push onto a full stack overwrites the oldest slot; depth saturates.
    if (push) begin
      sp_d = sp_q + SP_W'(1);
      if (depth_q == FULL) begin
        ovf_d = 1'b1;
      end else begin
        depth_d = depth_q + DEPTH_W'(1);
      end
    end
    if (pop) begin
      sp_d    = sp_q - SP_W'(1);
      depth_d = depth_q - DEPTH_W'(1);
    end

    case (state_q)
      RUN:     if (accept && halt) state_d = HALTED;
      HALTED:  if (resume)         state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      sp_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  generate
    for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          stack_q[gi] <= '0;
        end else if (push && (sp_q == SP_W'(gi))) begin
          stack_q[gi] <= pc_inc;
        end
      end
    end
  endgenerate

  assign pcNext          = rst ? pc_next_c : '0;
  assign enable          = accept;
  assign halted          = (state_q == HALTED);
  assign stack_depth     = depth_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;

endmodule
